// File: rtl/chess_clock_controls_if.sv
// Chess clock control bundle: raw board buttons and timeout in,
// decoded game-control levels and load strobe out.
interface chess_clock_controls_if;
  logic       i_btn_a;
  logic       i_btn_b;
  logic       i_btn_set;
  logic       i_btn_up;
  logic       i_timeout;
  logic       o_sw_turn;
  logic [3:0] o_init_a;
  logic [3:0] o_init_b;
  logic       o_init_load;
  logic       o_run;
  logic [1:0] o_setup;

  modport master (
    output i_btn_a,
    output i_btn_b,
    output i_btn_set,
    output i_btn_up,
    output i_timeout,
    input  o_sw_turn,
    input  o_init_a,
    input  o_init_b,
    input  o_init_load,
    input  o_run,
    input  o_setup
  );

  modport slave (
    input  i_btn_a,
    input  i_btn_b,
    input  i_btn_set,
    input  i_btn_up,
    input  i_timeout,
    output o_sw_turn,
    output o_init_a,
    output o_init_b,
    output o_init_load,
    output o_run,
    output o_setup
  );
endinterface

// File: rtl/chess_clock_controls.sv
// Chess clock front end: button sync/debounce and the
// game-control state machine driving the timekeeping block.
module chess_clock_controls #(
  parameter int p_debounce     = 500_000,
  parameter int p_init_max     = 9,
  parameter int p_init_default = 5
) (
  input logic             i_clk_50m,
  input logic             i_rst,
  chess_clock_controls_if.slave bus
);

  localparam int CW = $clog2(p_debounce + 1);

  // Button lanes: bit0 = A, bit1 = B, bit2 = set, bit3 = up
  localparam int BA = 0;
  localparam int BB = 1;
  localparam int BS = 2;
  localparam int BU = 3;

  typedef enum logic [2:0] {
    S_SETUP_A,
    S_SETUP_B,
    S_READY,
    S_RUN_A,
    S_RUN_B,
    S_OVER
  } state_t;

  logic [3:0]         raw;
  logic [3:0]         sync1_q;
  logic [3:0]         sync2_q;
  logic [3:0]         acc_q;
  logic [3:0]         acc_d;
  logic [3:0]         press_q;
  logic [3:0]         press_d;
  logic [3:0][CW-1:0] cnt_q;
  logic [3:0][CW-1:0] cnt_d;

  state_t     state_q;
  logic       turn_q;
  logic [3:0] init_a_q;
  logic [3:0] init_b_q;
  logic       load_q;
  logic       run_q;
  logic [1:0] setup_q;

  logic ev_a;
  logic ev_b;
  logic ev_set;
  logic ev_up;

  assign raw = {bus.i_btn_up, bus.i_btn_set,
                bus.i_btn_b, bus.i_btn_a};

  assign ev_a   = press_q[BA];
  assign ev_b   = press_q[BB];
  assign ev_set = press_q[BS];
  assign ev_up  = press_q[BU];

  function automatic logic [3:0] inc_init(
    input logic [3:0] v
  );
    if (v >= 4'(p_init_max)) return 4'd1;
    return v + 4'd1;
  endfunction

  // Two-flop synchronisers for the raw buttons
  always_ff @(posedge i_clk_50m or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count cycles of disagreement, accept after p_debounce
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    press_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == acc_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(p_debounce)) begin
        cnt_d[i]   = '0;
        acc_d[i]   = sync2_q[i];
        press_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debounce state and one-cycle press pulses
  always_ff @(posedge i_clk_50m or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      press_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      press_q <= press_d;
    end
  end

  // Game-control FSM with registered decoded outputs
  always_ff @(posedge i_clk_50m or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_SETUP_A;
      turn_q   <= 1'b0;
      init_a_q <= 4'(p_init_default);
      init_b_q <= 4'(p_init_default);
      load_q   <= 1'b0;
      run_q    <= 1'b0;
      setup_q  <= 2'b01;
    end else begin
      load_q <= 1'b0;
      unique case (state_q)
        S_SETUP_A: begin
          if (ev_set) begin
            state_q <= S_SETUP_B;
            setup_q <= 2'b10;
          end else if (ev_up) begin
            init_a_q <= inc_init(init_a_q);
          end
        end
        S_SETUP_B: begin
          if (ev_set) begin
            state_q <= S_READY;
            setup_q <= 2'b00;
          end else if (ev_up) begin
            init_b_q <= inc_init(init_b_q);
          end
        end
        S_READY: begin
          if (ev_b) begin
            state_q <= S_RUN_A;
            run_q   <= 1'b1;
            turn_q  <= 1'b0;
            load_q  <= 1'b1;
          end else if (ev_set) begin
            state_q <= S_SETUP_A;
            setup_q <= 2'b01;
          end
        end
        S_RUN_A: begin
          if (bus.i_timeout) begin
            state_q <= S_OVER;
            run_q   <= 1'b0;
          end else if (ev_a) begin
            state_q <= S_RUN_B;
            turn_q  <= 1'b1;
          end
        end
        S_RUN_B: begin
          if (bus.i_timeout) begin
            state_q <= S_OVER;
            run_q   <= 1'b0;
          end else if (ev_b) begin
            state_q <= S_RUN_A;
            turn_q  <= 1'b0;
          end
        end
        S_OVER: begin
          if (ev_set) begin
            state_q <= S_SETUP_A;
            turn_q  <= 1'b0;
            setup_q <= 2'b01;
          end
        end
        default: begin
          state_q <= S_SETUP_A;
          turn_q  <= 1'b0;
          run_q   <= 1'b0;
          setup_q <= 2'b01;
        end
      endcase
    end
  end

  assign bus.o_sw_turn   = turn_q;
  assign bus.o_init_a    = init_a_q;
  assign bus.o_init_b    = init_b_q;
  assign bus.o_init_load = load_q;
  assign bus.o_run       = run_q;
  assign bus.o_setup     = setup_q;

endmodule

// File: tb/tb_chess_clock_controls.sv
// Directed bench for chess_clock_controls with a 4-cycle
// debounce; inputs change on negedge, outputs sampled on negedge.
module tb_chess_clock_controls;

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nerr;

  chess_clock_controls_if bus ();

  chess_clock_controls #(
    .p_debounce    (4),
    .p_init_max    (9),
    .p_init_default(5)
  ) dut (
    .i_clk_50m(clk),
    .i_rst    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // m = {up, set, b, a}
  task automatic drive(input logic [3:0] m);
    bus.i_btn_a   = m[0];
    bus.i_btn_b   = m[1];
    bus.i_btn_set = m[2];
    bus.i_btn_up  = m[3];
  endtask

  task automatic press(input logic [3:0] m);
    drive(m);
    repeat (10) @(negedge clk);
    drive(4'b0000);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(4'b0000);
    bus.i_timeout = 1'b0;
    repeat (3) @(negedge clk);
    ncmp++;
    if (bus.o_setup !== 2'b01) begin
      nerr++;
      $display("FAIL rst_setup got %b want 01", bus.o_setup);
    end
    rst_n = 1'b1;
    @(negedge clk);
    ncmp++;
    if ({bus.o_run, bus.o_sw_turn, bus.o_init_load} !== 3'b000) begin
      nerr++;
      $display("FAIL rst_ctl got %b want 000",
        {bus.o_run, bus.o_sw_turn, bus.o_init_load});
    end
    ncmp++;
    if ({bus.o_init_a, bus.o_init_b} !== 8'h55) begin
      nerr++;
      $display("FAIL rst_init got %h want 55",
        {bus.o_init_a, bus.o_init_b});
    end
    ncmp++;
    if (bus.o_setup !== 2'b01) begin
      nerr++;
      $display("FAIL rel_setup got %b want 01", bus.o_setup);
    end
  endtask

  task automatic test_setup;
    logic [3:0] exp_a [5];
    exp_a = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd1};
    for (int i = 0; i < 5; i++) begin
      press(4'b1000);
      ncmp++;
      if (bus.o_init_a !== exp_a[i]) begin
        nerr++;
        $display("FAIL up_a[%0d] got %0d want %0d",
          i, bus.o_init_a, exp_a[i]);
      end
    end
    // set together with up: set wins, up dropped
    press(4'b1100);
    ncmp++;
    if (bus.o_setup !== 2'b10) begin
      nerr++;
      $display("FAIL set_up_setup got %b want 10", bus.o_setup);
    end
    ncmp++;
    if ({bus.o_init_a, bus.o_init_b} !== 8'h15) begin
      nerr++;
      $display("FAIL set_up_drop got %h want 15",
        {bus.o_init_a, bus.o_init_b});
    end
    press(4'b1000);
    press(4'b1000);
    press(4'b0100);
    ncmp++;
    if (bus.o_init_b !== 4'd7) begin
      nerr++;
      $display("FAIL init_b got %0d want 7", bus.o_init_b);
    end
    ncmp++;
    if ({bus.o_setup, bus.o_run} !== 3'b000) begin
      nerr++;
      $display("FAIL ready got %b want 000",
        {bus.o_setup, bus.o_run});
    end
    // READY ignores btn_a and up
    press(4'b1001);
    ncmp++;
    if ({bus.o_init_b, bus.o_setup, bus.o_run} !== 7'b0111_000) begin
      nerr++;
      $display("FAIL ready_ign got %b want 0111000",
        {bus.o_init_b, bus.o_setup, bus.o_run});
    end
  endtask

  task automatic test_start;
    drive(4'b0010);
    repeat (7) @(negedge clk);
    ncmp++;
    if (bus.o_run !== 1'b0) begin
      nerr++;
      $display("FAIL start_early got %b want 0", bus.o_run);
    end
    @(negedge clk);
    ncmp++;
    if ({bus.o_run, bus.o_init_load, bus.o_sw_turn} !== 3'b110) begin
      nerr++;
      $display("FAIL start_edge got %b want 110",
        {bus.o_run, bus.o_init_load, bus.o_sw_turn});
    end
    @(negedge clk);
    ncmp++;
    if ({bus.o_run, bus.o_init_load} !== 2'b10) begin
      nerr++;
      $display("FAIL load_once got %b want 10",
        {bus.o_run, bus.o_init_load});
    end
    drive(4'b0000);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_turns;
    drive(4'b0001);
    repeat (3) @(negedge clk);
    drive(4'b0000);
    repeat (12) @(negedge clk);
    ncmp++;
    if ({bus.o_run, bus.o_sw_turn} !== 2'b10) begin
      nerr++;
      $display("FAIL glitch got %b want 10",
        {bus.o_run, bus.o_sw_turn});
    end
    press(4'b0001);
    ncmp++;
    if (bus.o_sw_turn !== 1'b1) begin
      nerr++;
      $display("FAIL turn_b got %b want 1", bus.o_sw_turn);
    end
    press(4'b0011);
    ncmp++;
    if (bus.o_sw_turn !== 1'b0) begin
      nerr++;
      $display("FAIL both got %b want 0", bus.o_sw_turn);
    end
    press(4'b0001);
    ncmp++;
    if ({bus.o_run, bus.o_sw_turn} !== 2'b11) begin
      nerr++;
      $display("FAIL run_b got %b want 11",
        {bus.o_run, bus.o_sw_turn});
    end
  endtask

  task automatic test_timeout;
    drive(4'b0010);
    repeat (7) @(negedge clk);
    bus.i_timeout = 1'b1;
    @(negedge clk);
    bus.i_timeout = 1'b0;
    ncmp++;
    if ({bus.o_run, bus.o_sw_turn} !== 2'b01) begin
      nerr++;
      $display("FAIL over got %b want 01",
        {bus.o_run, bus.o_sw_turn});
    end
    drive(4'b0000);
    repeat (10) @(negedge clk);
    press(4'b0010);
    ncmp++;
    if ({bus.o_run, bus.o_sw_turn} !== 2'b01) begin
      nerr++;
      $display("FAIL over_hold got %b want 01",
        {bus.o_run, bus.o_sw_turn});
    end
    press(4'b0100);
    ncmp++;
    if (bus.o_setup !== 2'b01) begin
      nerr++;
      $display("FAIL over_set got %b want 01", bus.o_setup);
    end
    ncmp++;
    if ({bus.o_init_a, bus.o_init_b} !== 8'h17) begin
      nerr++;
      $display("FAIL retain got %h want 17",
        {bus.o_init_a, bus.o_init_b});
    end
  endtask

  task automatic test_reset_mid;
    press(4'b0100);
    press(4'b0100);
    press(4'b0010);
    ncmp++;
    if ({bus.o_run, bus.o_sw_turn} !== 2'b10) begin
      nerr++;
      $display("FAIL mid_runa got %b want 10",
        {bus.o_run, bus.o_sw_turn});
    end
    drive(4'b0001);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    ncmp++;
    if ({bus.o_run, bus.o_setup, bus.o_init_a, bus.o_init_b}
        !== 11'b0_01_0101_0101) begin
      nerr++;
      $display("FAIL mid_rst got %b want 00101010101",
        {bus.o_run, bus.o_setup, bus.o_init_a, bus.o_init_b});
    end
    drive(4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    ncmp++;
    if ({bus.o_run, bus.o_sw_turn, bus.o_setup} !== 4'b0001) begin
      nerr++;
      $display("FAIL mid_after got %b want 0001",
        {bus.o_run, bus.o_sw_turn, bus.o_setup});
    end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    test_reset();
    test_setup();
    test_start();
    test_turns();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      ncmp, nerr);
    $finish;
  end

endmodule
